// File: rtl/mem_arb_pkg.sv
// Shared types, size codes and address helpers for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  // RISC-V funct3 size codes; bit 2 only marks unsigned loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Returned to fetch when the memory never answers (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr[0];
      F3_W:        mis = (addr != 2'b00);
      default:     mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

  // Store byte enables for the addressed lanes.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr;
      F3_H, F3_HU: be = 4'b0011 << {addr[1], 1'b0};
      F3_W:        be = 4'hF;
      default:     be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Store lane steering: byte enables and replicated write data from size/offset.
module mem_byte_lane
  import mem_arb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata
);

  // Replicate the low byte/halfword into every lane so be alone selects the target.
  always_comb begin
    be = byte_en(funct3, addr_lo);
    case (funct3)
      F3_B, F3_BU: lane_wdata = {4{wdata[7:0]}};
      F3_H, F3_HU: lane_wdata = {2{wdata[15:0]}};
      default:     lane_wdata = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one valid/ready memory bus.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR_OR    = 32'h8000_0000,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [TW-1:0] timer, timer_nxt;

  logic        valid_nxt, we_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [3:0]  be_nxt;
  logic        if_ready_nxt, d_ready_nxt, d_err_nxt;
  logic [31:0] if_rdata_nxt, d_rdata_nxt;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] data_addr;
  logic [31:0] fetch_addr;
  logic        pulse;
  logic        d_mis;

  mem_byte_lane u_lane (
    .funct3     (d_funct3),
    .addr_lo    (d_addr[1:0]),
    .wdata      (d_wdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata)
  );

  assign data_addr  = (d_addr | DATA_ADDR_OR) & ~32'h3;
  assign fetch_addr = if_addr & ~32'h3;
  assign d_mis      = misaligned(d_funct3, d_addr[1:0]);
  // Ready pulses are registered, so the requester still holds req during the
  // pulse cycle; refusing grants then avoids re-serving the same request and
  // guarantees an idle bus cycle between accesses.
  assign pulse      = if_ready | d_ready;

  // State, counters and all outputs are registered; reset abandons any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      timer     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      timer     <= timer_nxt;
      mem_valid <= valid_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_be    <= be_nxt;
      if_ready  <= if_ready_nxt;
      if_rdata  <= if_rdata_nxt;
      d_ready   <= d_ready_nxt;
      d_rdata   <= d_rdata_nxt;
      d_err     <= d_err_nxt;
    end
  end

  // Grant selection, completion/timeout handling and next output values.
  always_comb begin
    state_nxt    = state;
    streak_nxt   = streak;
    timer_nxt    = timer;
    valid_nxt    = mem_valid;
    we_nxt       = mem_we;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    be_nxt       = mem_be;
    if_ready_nxt = 1'b0;
    if_rdata_nxt = '0;
    d_ready_nxt  = 1'b0;
    d_rdata_nxt  = '0;
    d_err_nxt    = 1'b0;

    if (!if_req) streak_nxt = '0;

    case (state)
      IDLE: begin
        if (!pulse) begin
          if (d_req && d_mis) begin
            d_ready_nxt = 1'b1;
            d_err_nxt   = 1'b1;
          end else if (d_req && (!if_req || streak < STREAK_MAX)) begin
            state_nxt  = DATA;
            valid_nxt  = 1'b1;
            we_nxt     = d_we;
            addr_nxt   = data_addr;
            be_nxt     = d_we ? lane_be : 4'hF;
            wdata_nxt  = d_we ? lane_wdata : '0;
            timer_nxt  = '0;
            streak_nxt = if_req ? streak + SW'(1) : '0;
          end else if (if_req) begin
            state_nxt  = FETCH;
            valid_nxt  = 1'b1;
            we_nxt     = 1'b0;
            addr_nxt   = fetch_addr;
            be_nxt     = 4'hF;
            wdata_nxt  = '0;
            timer_nxt  = '0;
            streak_nxt = '0;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ready || timer == TIMER_LAST) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          if (state == FETCH) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = mem_ready ? mem_rdata : NOP_INSN;
          end else begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = mem_ready ? mem_rdata : '0;
            d_err_nxt   = !mem_ready;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reference model plus directed cases.
module tb_mem_port_arbiter;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned MAXS    = 4;
  localparam logic [31:0] OR_MASK = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_funct3 = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(
    .DATA_ADDR_OR    (OR_MASK),
    .MAX_DATA_STREAK (MAXS),
    .TIMEOUT         (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_funct3  (d_funct3),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a % 4) % int'(size_bytes(f3))) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    sz = size_bytes(f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned sz;
    sz = size_bytes(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  int          m_owner = 0;   // 0 none, 1 fetch access in flight, 2 data access in flight
  int          m_vc = 0;      // bus cycles the current access has been outstanding
  int          m_streak = 0;  // data grants in a row while fetch was waiting
  logic        e_valid = 0, e_we = 0, e_ifr = 0, e_dr = 0, e_err = 0, e_dd_chk = 0;
  logic [31:0] e_addr = '0, e_wd = '0, e_ifd = '0, e_dd = '0;
  logic [3:0]  e_be = '0;

  always @(posedge clk) begin
    bit was_pulse, gd, gf;
    was_pulse = e_ifr || e_dr;
    gd = 0;
    gf = 0;
    e_ifr = 0;
    e_dr = 0;
    e_err = 0;
    e_dd_chk = 0;
    if (reset) begin
      m_owner = 0; m_vc = 0; m_streak = 0;
      e_valid = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
    end else begin
      if (m_owner != 0) begin
        m_vc++;
        if (mem_ready || m_vc == int'(TIMEOUT)) begin
          e_valid = 0;
          if (m_owner == 1) begin
            e_ifr = 1;
            e_ifd = mem_ready ? mem_rdata : 32'h0000_0013;
          end else begin
            e_dr = 1;
            e_err = !mem_ready;
            e_dd = mem_ready ? mem_rdata : 32'h0;
            e_dd_chk = 1;
          end
          m_owner = 0;
        end
      end else if (!was_pulse) begin
        if (d_req && model_mis(d_funct3, d_addr)) begin
          e_dr = 1;
          e_err = 1;
        end else if (d_req && (!if_req || m_streak < int'(MAXS))) gd = 1;
        else if (if_req) gf = 1;
        if (gd) begin
          m_owner = 2; m_vc = 0; e_valid = 1; e_we = d_we;
          e_addr = (d_addr | OR_MASK) & ~32'h3;
          e_be = d_we ? model_be(d_funct3, d_addr) : 4'hF;
          e_wd = model_wd(d_funct3, d_wdata);
        end
        if (gf) begin
          m_owner = 1; m_vc = 0; e_valid = 1; e_we = 0;
          e_addr = if_addr & ~32'h3;
          e_be = 4'hF;
        end
      end
      if (!if_req) m_streak = 0;
      else if (gd) m_streak++;
      else if (gf) m_streak = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_valid", 32'(mem_valid), 32'(e_valid));
      check("if_ready", 32'(if_ready), 32'(e_ifr));
      check("d_ready", 32'(d_ready), 32'(e_dr));
      if (e_valid) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_be", 32'(mem_be), 32'(e_be));
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
      end
      if (e_ifr) check("if_rdata", if_rdata, e_ifd);
      if (e_dr) begin
        check("d_err", 32'(d_err), 32'(e_err));
        if (e_dd_chk) check("d_rdata", d_rdata, e_dd);
      end
    end
  end

  // ---------------- memory responder ----------------
  int          lat_cfg = 1;   // valid cycle on which mem_ready rises; 0 = never
  logic [31:0] rd_word = '0;
  int          vcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_valid) vcnt++;
    else vcnt = 0;
    mem_ready = mem_valid && lat_cfg != 0 && vcnt == lat_cfg;
    mem_rdata = rd_word;
  end

  // ---------------- grant log ----------------
  bit  log_en = 0;
  bit  prev_v = 0;
  byte grants[$];
  always @(negedge clk) begin
    if (log_en && mem_valid && !prev_v) grants.push_back(mem_addr[31] ? "D" : "F");
    prev_v = mem_valid;
  end

  // ---------------- single-access driver ----------------
  int          r_vcyc, r_pulses, r_when;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_err, r_we, r_stable;

  task automatic access(input bit is_d, input logic [31:0] a, input logic we,
                        input logic [2:0] f3, input logic [31:0] wd, input int lat,
                        input logic [31:0] rd);
    r_vcyc = 0; r_pulses = 0; r_when = -1; r_rdata = '0; r_err = 0;
    r_addr = '0; r_be = '0; r_wdata = '0; r_we = 0; r_stable = 1;
    @(posedge clk); #1;
    lat_cfg = lat;
    rd_word = rd;
    if (is_d) begin
      d_req = 1; d_addr = a; d_we = we; d_funct3 = f3; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    for (int i = 0; i < 400 && r_when < 0; i++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (r_vcyc > 0 && mem_addr !== r_addr) r_stable = 0;
        r_vcyc++;
        r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
      end
      if (is_d ? d_ready : if_ready) begin
        r_pulses++;
        r_when = i;
        r_rdata = is_d ? d_rdata : if_rdata;
        r_err = d_err;
      end
    end
    @(posedge clk); #1;
    if_req = 0;
    d_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) r_pulses++;
    end
  endtask

  string exp_seq;
  byte   g;
  int    extra;

  initial begin
    // reset
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_if_ready", 32'(if_ready), 32'h0);
    check("rst_d_ready", 32'(d_ready), 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 0;

    // fetch at 0x40, memory answers on the 3rd valid cycle
    access(0, 32'h40, 0, 3'b010, 0, 3, 32'h1234_5678);
    check("f40_valid_cycles", r_vcyc, 3);
    check("f40_addr", r_addr, 32'h40);
    check("f40_addr_stable", 32'(r_stable), 32'h1);
    check("f40_be", 32'(r_be), 32'hF);
    check("f40_pulses", r_pulses, 1);
    check("f40_rdata", r_rdata, 32'h1234_5678);

    // SB 0xAB to 0x103
    access(1, 32'h103, 1, 3'b000, 32'h0000_00AB, 1, 32'h0);
    check("sb_addr", r_addr, 32'h8000_0100);
    check("sb_be", 32'(r_be), 32'h8);
    check("sb_wdata", r_wdata, 32'hABAB_ABAB);
    check("sb_we", 32'(r_we), 32'h1);
    check("sb_pulses", r_pulses, 1);

    // SH 0xBEEF to 0x22
    access(1, 32'h22, 1, 3'b001, 32'h1234_BEEF, 2, 32'h0);
    check("sh_addr", r_addr, 32'h8000_0020);
    check("sh_be", 32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'hBEEF_BEEF);

    // zero-wait LW: ready two cycles after the request
    access(1, 32'h20, 0, 3'b010, 0, 1, 32'hCAFE_F00D);
    check("lw_latency", r_when, 2);
    check("lw_rdata", r_rdata, 32'hCAFE_F00D);
    check("lw_err", 32'(r_err), 32'h0);
    check("lw_be", 32'(r_be), 32'hF);

    // misaligned LW at 0x6: error without a bus access
    access(1, 32'h6, 0, 3'b010, 0, 1, 32'h0);
    check("mis_lw_valid_cycles", r_vcyc, 0);
    check("mis_lw_err", 32'(r_err), 32'h1);
    check("mis_lw_pulses", r_pulses, 1);
    check("mis_lw_latency", r_when, 1);

    // misaligned LHU at 0x101, aligned LBU at 0x103
    access(1, 32'h101, 0, 3'b101, 0, 1, 32'h0);
    check("mis_lhu_err", 32'(r_err), 32'h1);
    check("mis_lhu_valid_cycles", r_vcyc, 0);
    access(1, 32'h103, 0, 3'b100, 0, 2, 32'h5555_AAAA);
    check("lbu_err", 32'(r_err), 32'h0);
    check("lbu_be", 32'(r_be), 32'hF);
    check("lbu_addr", r_addr, 32'h8000_0100);

    // both requesting continuously, zero-wait memory
    lat_cfg = 1;
    grants.delete();
    log_en = 1;
    @(posedge clk); #1;
    if_addr = 32'h200; d_addr = 32'h10; d_we = 0; d_funct3 = 3'b010;
    if_req = 1; d_req = 1;
    for (int i = 0; i < 200 && grants.size() < 10; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) break;
    end
    @(posedge clk); #1;
    if_req = 0; d_req = 0;
    log_en = 0;
    exp_seq = "DDDDFDDDDF";
    for (int i = 0; i < 10; i++) begin
      g = (grants.size() > i) ? grants[i] : 8'h2D;
      check($sformatf("streak_seq[%0d]", i), 32'(g), 32'(exp_seq[i]));
    end
    repeat (3) @(posedge clk);

    // data timeout
    access(1, 32'h8, 1, 3'b010, 32'h1122_3344, 0, 32'hFFFF_FFFF);
    check("dto_valid_cycles", r_vcyc, 255);
    check("dto_err", 32'(r_err), 32'h1);
    check("dto_rdata", r_rdata, 32'h0);
    check("dto_pulses", r_pulses, 1);

    // fetch timeout returns a NOP
    access(0, 32'h44, 0, 3'b010, 0, 0, 32'hFFFF_FFFF);
    check("fto_valid_cycles", r_vcyc, 255);
    check("fto_rdata", r_rdata, 32'h0000_0013);

    // requester drops fetch req mid-access: the access still completes
    @(posedge clk); #1;
    lat_cfg = 4; rd_word = 32'h0BAD_F00D;
    if_req = 1; if_addr = 32'h90;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    if_req = 0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ready) begin
        extra++;
        check("drop_rdata", if_rdata, 32'h0BAD_F00D);
      end
    end
    check("drop_pulses", extra, 1);

    // reset in the middle of an access
    @(posedge clk); #1;
    lat_cfg = 0;
    if_req = 1; if_addr = 32'h80;
    repeat (5) @(negedge clk);
    check("rst_mid_pre_valid", 32'(mem_valid), 32'h1);
    @(posedge clk); #1;
    reset = 1; if_req = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", 32'(mem_valid), 32'h0);
    check("rst_mid_if_ready", 32'(if_ready), 32'h0);
    @(posedge clk); #1;
    reset = 0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) extra++;
    end
    check("rst_mid_no_pulse", extra, 0);
    access(0, 32'h84, 0, 3'b010, 0, 2, 32'h0000_0033);
    check("post_rst_valid_cycles", r_vcyc, 2);
    check("post_rst_addr", r_addr, 32'h84);
    check("post_rst_rdata", r_rdata, 32'h0000_0033);
    check("post_rst_pulses", r_pulses, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
